led_blink_sequencer: RTL and testbench



---
 rtl/led_blink_sequencer_if.sv | 25 ++
 rtl/led_blink_sequencer.sv | 121 ++++++++++++
 tb/tb_led_blink_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sequencer_if.sv
// Command/LED bundle for led_blink_sequencer: host drives commands, block drives LED and status.
interface led_blink_sequencer_if #(
   parameter int BLINK_W = 8,
   parameter int TIME_W  = 16
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [BLINK_W-1:0] cmd_blinks;
   logic [TIME_W-1:0]  cmd_on_t;
   logic [TIME_W-1:0]  cmd_off_t;
   logic               abort;
   logic               led;
   logic               busy;
   logic               done;

   modport master (
      output cmd_valid, cmd_blinks, cmd_on_t, cmd_off_t, abort,
      input  cmd_ready, led, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_blinks, cmd_on_t, cmd_off_t, abort,
      output cmd_ready, led, busy, done
   );
endinterface

// File: rtl/led_blink_sequencer.sv
// Command-driven LED blinker: N on/off pulses timed in prescaled ticks, with abort and a done pulse.
module led_blink_sequencer #(
   parameter int CLK_FREQ_KHz = 50000,
   parameter int TICK_HZ      = 1000,
   parameter int TICK_DIV     = (CLK_FREQ_KHz * 1000) / TICK_HZ,
   parameter int BLINK_W      = 8,
   parameter int TIME_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   led_blink_sequencer_if.slave   s_bus
);

   localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

   state_t             r_state, w_state_nxt;
   logic [PRE_W-1:0]   r_pre;
   logic [TIME_W-1:0]  r_cnt;
   logic [BLINK_W-1:0] r_rem;
   logic [TIME_W-1:0]  r_on_t, r_off_t;
   logic               r_led, r_busy, r_done, r_ready;
   logic               w_led_nxt, w_busy_nxt, w_done_nxt, w_ready_nxt;
   logic               w_accept, w_tick, w_expire;
   logic [TIME_W-1:0]  w_on_eff, w_off_eff;

   assign w_accept  = s_bus.cmd_valid && r_ready;
   assign w_tick    = (r_pre == PRE_MAX);
   assign w_expire  = w_tick && (r_cnt == TIME_W'(1));
   // Zero-length phases are stretched to one tick
   assign w_on_eff  = (s_bus.cmd_on_t  == '0) ? TIME_W'(1) : s_bus.cmd_on_t;
   assign w_off_eff = (s_bus.cmd_off_t == '0) ? TIME_W'(1) : s_bus.cmd_off_t;

   assign s_bus.cmd_ready = r_ready;
   assign s_bus.led       = r_led;
   assign s_bus.busy      = r_busy;
   assign s_bus.done      = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pre   <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_on_t  <= '0;
         r_off_t <= '0;
         r_led   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_led   <= w_led_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ready <= w_ready_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rem   <= s_bus.cmd_blinks;
                  r_on_t  <= w_on_eff;
                  r_off_t <= w_off_eff;
                  r_pre   <= '0;
                  r_cnt   <= w_on_eff;
               end
            end
            S_ON, S_OFF: begin
               if (s_bus.abort) begin
                  r_pre <= '0;
                  r_cnt <= '0;
                  r_rem <= '0;
               end else if (w_tick) begin
                  // Prescaler and phase counter reload together at each boundary
                  r_pre <= '0;
                  if (w_expire) begin
                     if (r_state == S_ON) begin
                        r_rem <= r_rem - BLINK_W'(1);
                        r_cnt <= r_off_t;
                     end else begin
                        r_cnt <= r_on_t;
                     end
                  end else begin
                     r_cnt <= r_cnt - TIME_W'(1);
                  end
               end else begin
                  r_pre <= r_pre + PRE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept && (s_bus.cmd_blinks != '0)) w_state_nxt = S_ON;
         S_ON: begin
            if (s_bus.abort)   w_state_nxt = S_IDLE;
            else if (w_expire) w_state_nxt = S_OFF;
         end
         S_OFF: begin
            if (s_bus.abort)   w_state_nxt = S_IDLE;
            else if (w_expire) w_state_nxt = (r_rem == '0) ? S_IDLE : S_ON;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered copies of decodes of the next state
   always_comb begin
      w_led_nxt   = (w_state_nxt == S_ON);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_ready_nxt = (w_state_nxt == S_IDLE);
      w_done_nxt  = ((r_state == S_IDLE) && w_accept && (s_bus.cmd_blinks == '0)) ||
                    ((r_state == S_OFF) && !s_bus.abort && w_expire && (r_rem == '0));
   end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench: per-cycle expected {led,busy,done,ready} queued at stimulus time, popped each cycle.
module tb_led_blink_sequencer;

   localparam int BW = 8;
   localparam int TW = 16;
   localparam int TD = 4;

   typedef struct packed {
      logic led;
      logic busy;
      logic done;
      logic rdy;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst;
   exp_t  q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   string tag = "init";

   led_blink_sequencer_if #(.BLINK_W(BW), .TIME_W(TW)) bus ();

   led_blink_sequencer #(
      .CLK_FREQ_KHz(4),
      .TICK_HZ     (1000),
      .BLINK_W     (BW),
      .TIME_W      (TW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .s_bus(bus)
   );

   always #5 clk = ~clk;

   task automatic push(input logic led, input logic busy, input logic done, input logic rdy, input int n);
      exp_t e;
      e = {led, busy, done, rdy};
      for (int i = 0; i < n; i++) q.push_back(e);
   endtask

   task automatic push_cmd(input int b, input int on, input int off);
      int onp, offp;
      onp  = (on  == 0) ? 1 : on;
      offp = (off == 0) ? 1 : off;
      for (int i = 0; i < b; i++) begin
         push(1, 1, 0, 0, onp * TD);
         push(0, 1, 0, 0, offp * TD);
      end
      push(0, 0, 1, 1, 1);
   endtask

   task automatic step();
      exp_t e, o;
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         o = {bus.led, bus.busy, bus.done, bus.cmd_ready};
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d led/busy/done/rdy got=%b want=%b", tag, cyc, o, e);
         end
      end
   endtask

   task automatic drain();
      while (q.size() > 0) step();
   endtask

   task automatic set_cmd(input int b, input int on, input int off);
      bus.cmd_blinks = BW'(b);
      bus.cmd_on_t   = TW'(on);
      bus.cmd_off_t  = TW'(off);
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.abort = 1'b0;
      set_cmd(0, 0, 0);

      tag = "reset";
      push(0, 0, 0, 1, 2);
      step(); step();
      rst = 1'b0;

      tag = "idle10";
      push(0, 0, 0, 1, 10);
      drain();

      tag = "b3_on2_off1";
      set_cmd(3, 2, 1);
      bus.cmd_valid = 1'b1;
      push_cmd(3, 2, 1);
      push(0, 0, 0, 1, 2);
      step();
      bus.cmd_valid = 1'b0;
      set_cmd(7, 9, 9);
      drain();

      tag = "blinks0";
      set_cmd(0, 5, 5);
      bus.cmd_valid = 1'b1;
      push_cmd(0, 5, 5);
      push(0, 0, 0, 1, 2);
      step();
      bus.cmd_valid = 1'b0;
      drain();

      tag = "zero_durations";
      set_cmd(2, 0, 0);
      bus.cmd_valid = 1'b1;
      push_cmd(2, 0, 0);
      push(0, 0, 0, 1, 2);
      step();
      bus.cmd_valid = 1'b0;
      drain();

      tag = "back_to_back";
      set_cmd(1, 1, 1);
      bus.cmd_valid = 1'b1;
      push_cmd(1, 1, 1);
      push_cmd(2, 1, 1);
      push(0, 0, 0, 1, 2);
      step();
      set_cmd(2, 1, 1);
      repeat (9) step();
      bus.cmd_valid = 1'b0;
      drain();

      tag = "abort_in_accept";
      set_cmd(1, 0, 0);
      bus.cmd_valid = 1'b1;
      bus.abort = 1'b1;
      push_cmd(1, 0, 0);
      push(0, 0, 0, 1, 1);
      step();
      bus.cmd_valid = 1'b0;
      bus.abort = 1'b0;
      drain();

      tag = "abort_on2";
      set_cmd(3, 2, 1);
      bus.cmd_valid = 1'b1;
      push(1, 1, 0, 0, 8);
      push(0, 1, 0, 0, 4);
      push(1, 1, 0, 0, 5);
      push(0, 0, 0, 1, 4);
      step();
      bus.cmd_valid = 1'b0;
      repeat (16) step();
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      drain();

      tag = "rst_mid_off";
      set_cmd(3, 2, 1);
      bus.cmd_valid = 1'b1;
      push(1, 1, 0, 0, 8);
      push(0, 1, 0, 0, 2);
      push(0, 0, 0, 1, 5);
      step();
      bus.cmd_valid = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      set_cmd(1, 1, 1);
      bus.cmd_valid = 1'b1;
      step();
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
